rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
Clocked round-robin arbiter that shares one resource among INPUTS requesters with a held (locked) grant. The owner keeps the grant until it pulses done, drops req, or exhausts a hold budget. Priority then rotates to the index after the owner, with zero-dead-cycle handoff to a waiting requester. It sits between requester request lines and the resource's select/mux logic.

Parameters:
INPUTS, 4, number of requesters; legal range 2..16
MAX_HOLD, 16, maximum consecutive cycles one grant may stay asserted; must be >= 1
OWNER_W, $clog2(INPUTS), width of owner_id; derived, not overridden

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req  in  INPUTS  per-requester request level, bit i = requester i
done  in  INPUTS  per-requester release pulse; only the owner's bit is honoured
grant  out  INPUTS  registered one-hot grant, or all zero
busy  out  1  registered; 1 while any grant is asserted
owner_id  out  OWNER_W  registered index of the current or last owner
timeout  out  1  registered one-cycle pulse when a grant ends because of MAX_HOLD

Behaviour:
- Reset is asynchronous on rst_n low and takes effect mid-operation. All of the following clear: grant=0, busy=0, owner_id=0, timeout=0, rotation pointer ptr=0, hold_cnt=0, state=IDLE. The first cycle after reset release is a normal IDLE evaluation.
- Registers: state {IDLE, OWNED}, ptr (OWNER_W bits), hold_cnt ($clog2(MAX_HOLD)+1 bits), grant, owner_id, timeout.
- Winner selection is combinational. Take the first set bit of the candidate vector, scanning indices ptr, ptr+1, ... with wrap modulo INPUTS.
- IDLE:
  - If |req is 1: grant<=onehot(winner over req), owner_id<=winner, hold_cnt<=0, state<=OWNED.
  - Otherwise everything holds.
  - Latency from req to grant is 1 clock.
- OWNED: release = done[owner_id] | ~req[owner_id] | (hold_cnt == MAX_HOLD-1).
  - No release: hold_cnt<=hold_cnt+1; grant and owner_id hold.
  - Release: ptr<=(owner_id+1) mod INPUTS. Candidates = req with the owner's bit masked. Selection scans from the new ptr value.
    - Candidates nonzero: grant<=onehot(winner), owner_id<=winner, hold_cnt<=0, stay OWNED. This is the no-gap handoff.
    - Candidates zero: grant<=0, state<=IDLE; owner_id keeps the last owner.
  - timeout<=1 for exactly one cycle only when release is caused solely by the hold limit (done[owner_id]=0 and req[owner_id]=1). Otherwise timeout<=0.
- A grant is therefore asserted for at most MAX_HOLD consecutive cycles to one owner.
- A released owner can never be re-granted in its release cycle. If it is the sole requester it sees exactly one grant=0 cycle, then is regranted from IDLE.
- done bits of non-owners, and all done bits in IDLE, are ignored.
- done[owner] together with req[owner] dropping in the same cycle is one release; timeout stays 0.
- Owner req high but done pulsed: release occurs. The owner keeps requesting and re-enters arbitration behind the others.
- grant is always zero or one-hot. busy == |grant every cycle.
- Wrap-around: ptr=INPUTS-1 followed by release of owner INPUTS-1 gives ptr=0.
- No combinational path from inputs to outputs.

Test Plan:
- Async reset: assert rst_n=0 mid-grant with grant=0010 -> grant=0000, busy=0, owner_id=0, timeout=0 immediately without a clock edge. Release reset with req=1000 -> grant=1000 after 1 clock.
- Single request: req=0100 (INPUTS=4) -> next edge grant=0100, owner_id=2, busy=1. done=0100 for 1 cycle with req held -> next edge grant=0000, busy=0, timeout=0.
- Rotation fairness: req=1111 held, owner pulses done 2 cycles after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with no zero cycle between owners.
- Handoff skip: owner=1, req=1011, done=0010 -> next edge grant=1000, owner_id=3 (index 2 not requesting, no gap). Then req drops to 0001 and done=1000 -> grant=0001 after wrap.
- Hold limit: MAX_HOLD=4, req=0001 held, done never asserted -> grant=0001 for exactly 4 cycles. timeout=1 for one cycle as grant drops, grant=0000 for 1 cycle, then grant=0001 again.
- Req drop and ignored done: owner=2, done=0001 (non-owner) -> no change. Then req[2] falls with req=0000 -> next edge grant=0000, state IDLE, timeout=0, owner_id stays 2.

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a locked grant: the owner holds the resource until
// it pulses done, drops req, or runs out of its MAX_HOLD cycle budget.
module rr_lock_arbiter #(
  parameter int INPUTS = 4,
  parameter int MAX_HOLD = 16,
  localparam int OWNER_W = $clog2(INPUTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INPUTS-1:0]  req,
  input  logic [INPUTS-1:0]  done,
  output logic [INPUTS-1:0]  grant,
  output logic               busy,
  output logic [OWNER_W-1:0] owner_id,
  output logic               timeout
);

  localparam int HCW = $clog2(MAX_HOLD) + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]     hold_q, hold_d;
  logic [INPUTS-1:0]  grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               timeout_q, timeout_d;

  logic               own_done, own_req, hit_limit, release_own;
  logic [OWNER_W-1:0] nxt_ptr, win_idle, win_hand;
  logic [INPUTS-1:0]  cand;

  // First set bit of cand, scanning upward from start with wrap-around.
  function automatic logic [OWNER_W-1:0] pick(input logic [INPUTS-1:0] c,
                                              input logic [OWNER_W-1:0] start);
    logic [OWNER_W-1:0] w;
    logic               f;
    int                 idx;
    w = '0;
    f = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      idx = (int'(start) + i) % INPUTS;
      if (!f && c[idx]) begin
        f = 1'b1;
        w = OWNER_W'(idx);
      end
    end
    return w;
  endfunction

  assign own_done    = done[owner_q];
  assign own_req     = req[owner_q];
  assign hit_limit   = (hold_q == HCW'(MAX_HOLD - 1));
  assign release_own = own_done | ~own_req | hit_limit;
  assign nxt_ptr     = (owner_q == OWNER_W'(INPUTS - 1)) ? '0 : owner_q + 1'b1;
  // The releasing owner is masked so it cannot win back its own slot.
  assign cand        = req & ~(INPUTS'(1) << owner_q);
  assign win_idle    = pick(req, ptr_q);
  assign win_hand    = pick(cand, nxt_ptr);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = INPUTS'(1) << win_idle;
          owner_d = win_idle;
          hold_d  = '0;
          state_d = OWNED;
        end
      end
      default: begin
        if (!release_own) begin
          hold_d = hold_q + 1'b1;
        end else begin
          ptr_d     = nxt_ptr;
          timeout_d = hit_limit & ~own_done & own_req;
          if (|cand) begin
            grant_d = INPUTS'(1) << win_hand;
            owner_d = win_hand;
            hold_d  = '0;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign owner_id = owner_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (INPUTS=4, MAX_HOLD=4) with hand-computed
// expected grant/owner/timeout values after each clock.
module tb_rr_lock_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       busy;
  logic [1:0] owner_id;
  logic       timeout;

  int nerr;
  int nchk;

  rr_lock_arbiter #(.INPUTS(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .busy(busy), .owner_id(owner_id), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                         input logic t);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_busy"}, 32'(busy), 32'(|g));
    chk({tag, "_owner"}, 32'(owner_id), 32'(o));
    chk({tag, "_timeout"}, 32'(timeout), 32'(t));
  endtask

  logic [3:0] rot [5];

  initial begin
    nerr = 0;
    nchk = 0;
    rst_n = 1'b1;
    req = 4'b0000;
    done = 4'b0000;
    rot[0] = 4'b1000; rot[1] = 4'b0001; rot[2] = 4'b0010;
    rot[3] = 4'b0100; rot[4] = 4'b1000;

    // reset state
    #2 rst_n = 1'b0;
    #1 chk_all("reset", 4'b0000, 2'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_all("idle_noreq", 4'b0000, 2'd0, 1'b0);

    // single request, released by done with req held
    req = 4'b0100;
    step();
    chk_all("single_grant", 4'b0100, 2'd2, 1'b0);
    done = 4'b0100;
    step();
    done = 4'b0000;
    chk_all("single_done", 4'b0000, 2'd2, 1'b0);
    req = 4'b0000;
    step();
    chk_all("single_idle", 4'b0000, 2'd2, 1'b0);

    // rotation with all requesting; ptr is 3 here
    req = 4'b1111;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rot%0d_new", i), 32'(grant), 32'(rot[i]));
      step();
      chk($sformatf("rot%0d_held", i), 32'(grant), 32'(rot[i]));
      done = rot[i];
      step();
      done = 4'b0000;
    end
    chk_all("rot_last", 4'b1000, 2'd3, 1'b0);

    // drive ownership to index 1, then skip the idle index 2
    done = 4'b1000;
    step();
    done = 4'b0000;
    chk_all("to_owner0", 4'b0001, 2'd0, 1'b0);
    done = 4'b0001;
    step();
    done = 4'b0000;
    chk_all("to_owner1", 4'b0010, 2'd1, 1'b0);
    req = 4'b1011;
    done = 4'b0010;
    step();
    done = 4'b0000;
    chk_all("skip_idx2", 4'b1000, 2'd3, 1'b0);
    req = 4'b0001;
    done = 4'b1000;
    step();
    done = 4'b0000;
    chk_all("wrap_to0", 4'b0001, 2'd0, 1'b0);

    // hold limit: granted cycle above plus three more, then timeout
    for (int i = 1; i < 4; i++) begin
      step();
      chk_all($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    step();
    chk_all("hold_timeout", 4'b0000, 2'd0, 1'b1);
    step();
    chk_all("hold_regrant", 4'b0001, 2'd0, 1'b0);

    // owner 0 drops req, handoff to 2; non-owner done ignored
    req = 4'b0100;
    step();
    chk_all("drop_handoff", 4'b0100, 2'd2, 1'b0);
    done = 4'b0001;
    step();
    done = 4'b0000;
    chk_all("nonowner_done", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    step();
    chk_all("req_drop_idle", 4'b0000, 2'd2, 1'b0);
    done = 4'b1111;
    step();
    done = 4'b0000;
    chk_all("idle_done_ign", 4'b0000, 2'd2, 1'b0);

    // async reset mid-grant; ptr is 3 so req 0010 scans 3,0,1
    req = 4'b0010;
    step();
    chk_all("pre_reset", 4'b0010, 2'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", 4'b0000, 2'd0, 1'b0);
    req = 4'b1000;
    step();
    chk_all("held_reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all("post_reset", 4'b1000, 2'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
